// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, defaults and round-robin helper for the FIFO write arbiter
package fifo_arb_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int SEL_W_DEF     = 2;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int PICK_W        = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // Scan last+1, last+2, ... with wrap at nreq; the previous owner is checked last.
    function automatic pick_t rr_pick(input logic [PICK_W-1:0] req_v,
                                      input logic [PICK_W-1:0] last,
                                      input int nreq);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 1; k <= PICK_W; k++) begin
            j = int'(last) + k;
            if (j >= nreq) j = j - nreq;
            if (k <= nreq && !p.found && req_v[j[2:0]]) begin
                p.found = 1'b1;
                p.idx   = 8'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer handshake and FIFO write-side bundle for the arbiter
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] datai;
    logic [NREQ-1:0]        ack;
    logic                   fifo_full;
    logic                   fifo_we;
    logic [DATA_W-1:0]      fifo_datai;
    logic [NREQ-1:0]        grant;
    logic [SEL_W-1:0]       owner;
    logic                   busy;

    modport master (
        output req, datai, fifo_full,
        input  ack, fifo_we, fifo_datai, grant, owner, busy
    );

    modport slave (
        input  req, datai, fifo_full,
        output ack, fifo_we, fifo_datai, grant, owner, busy
    );
endinterface

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational round-robin selector shared by write and read schedulers
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [PICK_W-1:0] req_ext;
    logic [PICK_W-1:0] last_ext;
    pick_t             pick;

    always_comb begin
        req_ext                 = '0;
        req_ext[NREQ-1:0]       = req;
        last_ext                = '0;
        last_ext[SEL_W-1:0]     = last;
        pick                    = rr_pick(req_ext, last_ext, NREQ);
        idx                     = SEL_W'(pick.idx);
        found                   = pick.found;
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin owner of a FIFO write port; FIFO_ARB_PRIO0_EN gives requester 0 priority in IDLE
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_OWN   = 1'(OWN);
    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    logic [0:0]       state;
    logic [NREQ-1:0]  grant_q;
    logic [SEL_W-1:0] owner_q;
    logic [SEL_W-1:0] last_q;
    logic [3:0]       cnt;
    logic [NREQ-1:0]  pick_req;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_found;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             we;
    logic             release_now;

`ifdef FIFO_ARB_PRIO0_EN
    assign pick_req = {bus.req[NREQ-1:1], 1'b0};
`else
    assign pick_req = bus.req;
`endif

    fifo_rr_pick #(.NREQ(NREQ), .SEL_W(SEL_W)) u_pick (
        .req   (pick_req),
        .last  (last_q),
        .idx   (rr_idx),
        .found (rr_found)
    );

    always_comb begin
`ifdef FIFO_ARB_PRIO0_EN
        if (bus.req[0]) begin
            pick_idx   = '0;
            pick_found = 1'b1;
        end else begin
            pick_idx   = rr_idx;
            pick_found = rr_found;
        end
`else
        pick_idx   = rr_idx;
        pick_found = rr_found;
`endif
    end

    // rst gates the write so a mid-burst reset never lands a word.
    always_comb begin
        we             = (state == ST_OWN) && bus.req[owner_q] && !bus.fifo_full && !rst;
        bus.ack        = '0;
        bus.ack[owner_q] = we;
        bus.fifo_datai = bus.datai[int'(owner_q)*DATA_W +: DATA_W];
        release_now    = (state == ST_OWN) && (!bus.req[owner_q] || (we && cnt == CNT_LAST));
    end

    assign bus.fifo_we = we;
    assign bus.grant   = grant_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state == ST_OWN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            cnt     <= '0;
            last_q  <= SEL_W'(NREQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner_q <= pick_idx;
                        grant_q <= NREQ'(1) << pick_idx;
                        cnt     <= '0;
                        state   <= ST_OWN;
                    end
                end
                default: begin
                    if (release_now) begin
                        state   <= ST_IDLE;
                        last_q  <= owner_q;
                        grant_q <= '0;
                    end else if (we) begin
                        cnt <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(4), .SEL_W(2), .DATA_W(8)) bus ();

    fifo_wr_arbiter #(.NREQ(4), .SEL_W(2), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef FIFO_ARB_PRIO0_EN
    localparam logic [3:0] T6_G9 = 4'b0001;
`else
    localparam logic [3:0] T6_G9 = 4'b1000;
`endif

    int checks = 0;
    int failures = 0;
    int full_writes = 0;

    logic [7:0] q0[$], q1[$], q2[$], q3[$];
    logic [7:0] wlog[$], olog[$];
    logic [3:0] tr_grant[$], tr_ack[$];
    logic       tr_we[$], tr_busy[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hdead, 32'(exp[i]));
    endtask

    task automatic drive();
        bus.req   = {q3.size() != 0, q2.size() != 0, q1.size() != 0, q0.size() != 0};
        bus.datai = {(q3.size() != 0) ? q3[0] : 8'h00, (q2.size() != 0) ? q2[0] : 8'h00,
                     (q1.size() != 0) ? q1[0] : 8'h00, (q0.size() != 0) ? q0[0] : 8'h00};
    endtask

    task automatic push(input int r, input logic [7:0] d);
        case (r)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
        drive();
    endtask

    // Sample at the falling edge, then retire acked words just after the rising edge.
    task automatic cycle(input int n);
        logic [3:0] a;
        repeat (n) begin
            @(negedge clk);
            tr_grant.push_back(bus.grant);
            tr_ack.push_back(bus.ack);
            tr_we.push_back(bus.fifo_we);
            tr_busy.push_back(bus.busy);
            if (bus.fifo_we) begin
                wlog.push_back(bus.fifo_datai);
                olog.push_back(8'(bus.owner));
                if (bus.fifo_full) full_writes++;
            end
            a = bus.ack;
            @(posedge clk);
            #1;
            if (a[0]) void'(q0.pop_front());
            if (a[1]) void'(q1.pop_front());
            if (a[2]) void'(q2.pop_front());
            if (a[3]) void'(q3.pop_front());
            drive();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        bus.fifo_full = 1'b0;
        drive();
        cycle(2);
        rst = 1'b0;
        wlog.delete(); olog.delete();
        tr_grant.delete(); tr_ack.delete(); tr_we.delete(); tr_busy.delete();
    endtask

    initial begin
        logic [7:0]  e[$];
        logic [7:0]  eo[$];
        logic [8:0]  g9;
        logic [14:0] g15;
        logic [3:0]  acc;

        bus.fifo_full = 1'b0;
        bus.req = '0;
        bus.datai = '0;
        do_reset();
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_owner", 32'(bus.owner), 32'h0);
        check("rst_we", 32'(bus.fifo_we), 32'h0);
        check("rst_ack", 32'(bus.ack), 32'h0);

        // single requester, burst split by MAX_BURST
        for (int i = 0; i < 6; i++) push(2, 8'h10 + 8'(i));
        cycle(10);
        e = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        check_seq("t1_words", wlog, e);
        g9 = '0;
        for (int i = 0; i < 9; i++) g9[i] = tr_we[i];
        check("t1_we_pattern", 32'(g9), 32'(9'b011011110));
        check("t1_ack1", 32'(tr_ack[1]), 32'h4);
        check("t1_grant1", 32'(tr_grant[1]), 32'h4);
        check("t1_grant5", 32'(tr_grant[5]), 32'h0);

        // all four requesting, one word per grant
        do_reset();
        for (int i = 0; i < 4; i++) push(i, 8'hA0 + 8'(i));
        cycle(12);
        push(0, 8'hA0);
        cycle(4);
        e  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        eo = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        check_seq("t2_words", wlog, e);
        check_seq("t2_owners", olog, eo);
        g15 = '0;
        for (int i = 0; i < 15; i++) g15[i] = tr_busy[i];
        check("t2_busy_pattern", 32'(g15), 32'(15'b110110110110110));

        // full backpressure mid-burst
        do_reset();
        for (int i = 0; i < 4; i++) push(1, 8'h31 + 8'(i));
        cycle(2);
        bus.fifo_full = 1'b1;
        cycle(5);
        bus.fifo_full = 1'b0;
        cycle(4);
        acc = '0;
        for (int i = 2; i <= 6; i++) acc = acc | tr_ack[i] | {3'b000, tr_we[i]};
        check("t3_stall_we_ack", 32'(acc), 32'h0);
        check("t3_grant2", 32'(tr_grant[2]), 32'h2);
        check("t3_grant6", 32'(tr_grant[6]), 32'h2);
        e = '{8'h31, 8'h32, 8'h33, 8'h34};
        check_seq("t3_words", wlog, e);
        check("t3_we9", 32'(tr_we[9]), 32'h1);
        check("t3_busy10", 32'(tr_busy[10]), 32'h0);

        // owner drops after 2 words, requester 3 pending
        do_reset();
        push(1, 8'h41); push(1, 8'h42); push(3, 8'h44);
        cycle(4);
        push(1, 8'h43);
        cycle(7);
        e  = '{8'h41, 8'h42, 8'h44, 8'h43};
        eo = '{8'd1, 8'd1, 8'd3, 8'd1};
        check_seq("t4_words", wlog, e);
        check_seq("t4_owners", olog, eo);
        check("t4_we3", 32'(tr_we[3]), 32'h0);
        check("t4_busy4", 32'(tr_busy[4]), 32'h0);
        check("t4_grant5", 32'(tr_grant[5]), 32'h8);

        // reset during the third word of a burst
        do_reset();
        for (int i = 0; i < 4; i++) push(2, 8'h51 + 8'(i));
        cycle(3);
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        check("t5_busy_after", 32'(bus.busy), 32'h0);
        check("t5_grant_after", 32'(bus.grant), 32'h0);
        push(0, 8'h60); push(1, 8'h61); push(3, 8'h63);
        cycle(14);
        check("t5_we3", 32'(tr_we[3]), 32'h0);
        check("t5_grant4", 32'(tr_grant[4]), 32'h0);
        check("t5_grant5", 32'(tr_grant[5]), 32'h1);
        e = '{8'h51, 8'h52, 8'h60, 8'h61, 8'h53, 8'h54, 8'h63};
        check_seq("t5_words", wlog, e);

        // requester 0 rises during owner 2's burst
        do_reset();
        push(1, 8'h80);
        cycle(3);
        push(1, 8'h81);
        for (int i = 0; i < 4; i++) push(2, 8'h71 + 8'(i));
        push(3, 8'h83);
        cycle(2);
        push(0, 8'h90);
        cycle(13);
        check("t6_grant7", 32'(tr_grant[7]), 32'h4);
        check("t6_grant9", 32'(tr_grant[9]), 32'(T6_G9));
`ifdef FIFO_ARB_PRIO0_EN
        e = '{8'h80, 8'h71, 8'h72, 8'h73, 8'h74, 8'h90, 8'h81, 8'h83};
`else
        e = '{8'h80, 8'h71, 8'h72, 8'h73, 8'h74, 8'h83, 8'h90, 8'h81};
`endif
        check_seq("t6_words", wlog, e);

        check("no_write_when_full", 32'(full_writes), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter sharing the single write port of one FIFO instance between NREQ producers. Each producer presents a word with a req/ack handshake; the arbiter grants one owner at a time and forwards its words to the FIFO's we/datai while honouring the FIFO's full flag. It sits directly in front of the FIFO write side. The read side is untouched.

Parameters:
NREQ, 4, number of requesters (2..8)
SEL_W, 2, owner index width (>= clog2(NREQ))
DATA_W, 8, data width, equal to the FIFO DATA_W
MAX_BURST, 4, maximum words written per grant before forced release (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req  in  NREQ  per-requester word-valid
datai  in  NREQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W]
ack  out  NREQ  per-requester word-accepted strobe
fifo_full  in  1  FIFO full flag
fifo_we  out  1  FIFO write enable
fifo_datai  out  DATA_W  FIFO write data
grant  out  NREQ  one-hot current owner (registered)
owner  out  SEL_W  index of current owner (valid while busy)
busy  out  1  high in state OWN

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, grant=0, owner=0, busy=0, burst count=0, last owner=NREQ-1 (requester 0 wins first). fifo_we and ack are combinationally 0 in IDLE.
- Requester rule: a requester raises req[i] with stable data and holds both until it sees ack[i]=1 at a clock edge. One ack equals one word. Dropping req without ack is allowed and no word is written.
- State IDLE:
  - If any req is high, select the first requester scanning last+1, last+2, … with modulo-NREQ wrap.
  - Register owner and grant, clear the burst count, and go to OWN.
  - No write happens in IDLE, so arbitration costs 1 bubble cycle.
- State OWN:
  - fifo_we = req[owner] & ~fifo_full.
  - fifo_datai = datai slice of owner, driven combinationally from the mux.
  - ack[owner] = fifo_we. All other ack bits are 0.
  - Each fifo_we increments the burst count.
  - Release to IDLE (set last=owner, clear grant and busy) at the end of the cycle when either:
    - req[owner]=0, or
    - fifo_we=1 and the burst count equals MAX_BURST-1.
- fifo_full high in OWN: no write and no ack. The owner keeps the grant and the count is unchanged; this stall is unbounded.
- Simultaneous release and new requests: the next cycle is always IDLE, so there is no back-to-back grant without a bubble. The next arbitration excludes nobody; the releasing owner is simply lowest priority.
- Throughput: at most MAX_BURST words per MAX_BURST+1 cycles per grant.
- rst in OWN mid-burst: return to the reset state in the next cycle. No write occurs in the reset cycle (fifo_we forced to 0 while rst=1).
- The arbiter never drives fifo_we when fifo_full=1.

Optional Feature:
FIFO_ARB_PRIO0_EN
- Defined: in IDLE, requester 0 wins whenever req[0]=1, regardless of the round-robin pointer. Other requesters keep round-robin order among themselves. No preemption of a current owner.
- Undefined: pure round-robin as described above.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state enum (IDLE=1'b0, OWN=1'b1);
  - default NREQ, DATA_W and MAX_BURST constants;
  - function rr_pick(req, last) returning the next index.
- Natural sub-module: fifo_rr_pick, a combinational round-robin selector (req vector and last index in; index and found flag out). It is reused by the future read-side scheduler.
- The burst counter and FSM stay in fifo_wr_arbiter.

Test Plan:
1. Single requester: req[2]=1 with 6 words, MAX_BURST=4, full=0 -> IDLE (1 cycle), 4 writes with ack[2], IDLE bubble, then 2 writes. Words reach the FIFO in order 0x10..0x15.
2. All 4 requesting continuously after reset, one word each -> grant order 0,1,2,3,0. Each grant is preceded by 1 idle cycle and each write carries the owner's data (0xA0+i).
3. Full backpressure: owner 1 mid-burst, fifo_full=1 for 5 cycles -> fifo_we=0 and ack=0 for those 5 cycles, grant holds at 0b0010. Writing resumes after full drops and the count is preserved.
4. Owner drops req after 2 words, requesters 1 and 3 pending, last=1 -> release, then grant goes to 3 (round-robin past 2). No third word is written.
5. rst asserted for 1 cycle during the 3rd word of a burst -> fifo_we=0 in that cycle. busy=0 and grant=0 next cycle. The next arbitration with req=4'b1111 grants requester 0.
6. FIFO_ARB_PRIO0_EN defined, req=4'b1110 pending with req[0] rising during owner 2's burst -> owner 2 completes its burst, then requester 0 is granted ahead of requester 3.
